// File: rtl/mips_cpu_control_fsm.sv
// mips_cpu_control_fsm: multi-cycle MIPS control unit with memory stalls, a mult/div
// stall counter, an invalid-opcode pulse and a HALT state entered on a fetch from PC 0.
module mips_cpu_control_fsm #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic [4:0] rt,
    input  logic       waitrequest,
    input  logic       pc_zero,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       alusrc,
    output logic       branch,
    output logic       jump,
    output logic       muldiv_busy,
    output logic       invalid_instr,
    output logic       active,
    output logic [1:0] regdst,
    output logic [1:0] memtoreg,
    output logic [2:0] state
);
    localparam logic [2:0] FETCH  = 3'd0;
    localparam logic [2:0] DECODE = 3'd1;
    localparam logic [2:0] EXEC   = 3'd2;
    localparam logic [2:0] MEM    = 3'd3;
    localparam logic [2:0] WB     = 3'd4;
    localparam logic [2:0] MULDIV = 3'd5;
    localparam logic [2:0] HALT   = 3'd6;
    localparam int CW = $clog2(63 + 1);
    localparam logic [CW-1:0] MULT_LAST = CW'(MULT_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LAST  = CW'(DIV_CYCLES - 1);

    logic [2:0]    nxt;
    logic [CW-1:0] cnt;
    logic          d_valid, d_load, d_store, d_muldiv, d_div, d_write;
    logic          d_alusrc, d_branch, d_jump;
    logic [1:0]    d_regdst, d_memtoreg;
    logic          in_instr;
    logic          unused_rt;

    assign unused_rt = ^rt[3:0];

    always_comb begin
        d_valid    = 1'b1;
        d_load     = 1'b0;
        d_store    = 1'b0;
        d_muldiv   = 1'b0;
        d_div      = 1'b0;
        d_write    = 1'b0;
        d_alusrc   = 1'b0;
        d_branch   = 1'b0;
        d_jump     = 1'b0;
        d_regdst   = 2'b00;
        d_memtoreg = 2'b00;
        case (opcode)
            6'd0: begin
                d_muldiv   = funct[5:2] == 4'b0110;
                d_div      = d_muldiv && funct[1];
                d_jump     = funct == 6'h08 || funct == 6'h09;
                d_write    = !(d_muldiv || funct == 6'h08 || funct == 6'h11 || funct == 6'h13);
                d_regdst   = 2'b01;
                d_memtoreg = funct == 6'h09 ? 2'b10 : 2'b00;
            end
            6'd1: begin
                d_branch   = 1'b1;
                d_write    = rt[4];
                d_regdst   = rt[4] ? 2'b10 : 2'b00;
                d_memtoreg = rt[4] ? 2'b10 : 2'b00;
            end
            6'd2: d_jump = 1'b1;
            6'd3: begin
                d_jump     = 1'b1;
                d_write    = 1'b1;
                d_regdst   = 2'b10;
                d_memtoreg = 2'b10;
            end
            6'd4, 6'd5, 6'd6, 6'd7: d_branch = 1'b1;
            6'd9, 6'd10, 6'd11, 6'd12, 6'd13, 6'd14, 6'd15: begin
                d_alusrc = 1'b1;
                d_write  = 1'b1;
            end
            6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38: begin
                d_load     = 1'b1;
                d_alusrc   = 1'b1;
                d_write    = 1'b1;
                d_memtoreg = 2'b01;
            end
            6'd40, 6'd41, 6'd43: begin
                d_store  = 1'b1;
                d_alusrc = 1'b1;
            end
            default: d_valid = 1'b0;
        endcase
    end

    always_comb begin
        nxt = state;
        case (state)
            FETCH:   nxt = pc_zero ? HALT : waitrequest ? FETCH : DECODE;
            DECODE:  nxt = EXEC;
            EXEC:    nxt = (d_load || d_store) ? MEM : d_muldiv ? MULDIV : d_write ? WB : FETCH;
            MEM:     nxt = waitrequest ? MEM : d_load ? WB : FETCH;
            WB:      nxt = FETCH;
            MULDIV:  nxt = cnt == (d_div ? DIV_LAST : MULT_LAST) ? FETCH : MULDIV;
            HALT:    nxt = HALT;
            default: nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= FETCH;
            cnt   <= '0;
        end else begin
            state <= nxt;
            cnt   <= state == MULDIV ? cnt + 1'b1 : '0;
        end
    end

    // reset_n gates every strobe so they drop the moment reset asserts
    assign in_instr      = reset_n && state != FETCH && state < HALT;
    assign mem_read      = reset_n && ((state == FETCH && !pc_zero) || (state == MEM && d_load));
    assign ir_write      = reset_n && state == FETCH && !pc_zero && !waitrequest;
    assign mem_write     = reset_n && state == MEM && d_store;
    assign pc_write      = reset_n && state == EXEC;
    assign reg_write     = reset_n && state == WB;
    assign branch        = reset_n && state == EXEC && d_branch;
    assign jump          = reset_n && state == EXEC && d_jump;
    assign invalid_instr = reset_n && state == EXEC && !d_valid;
    assign muldiv_busy   = reset_n && state == MULDIV;
    assign active        = state != HALT;
    assign alusrc        = in_instr && d_alusrc;
    assign regdst        = in_instr && d_write ? d_regdst : 2'b00;
    assign memtoreg      = in_instr && d_write ? d_memtoreg : 2'b00;
endmodule

// File: tb/tb_mips_cpu_control_fsm.sv
// tb_mips_cpu_control_fsm: directed instruction sequences with per-cycle expected
// control vectors queued by the stimulus and checked by an independent monitor.
module tb_mips_cpu_control_fsm;
    logic       clk, reset_n, waitrequest, pc_zero;
    logic [5:0] opcode, funct;
    logic [4:0] rt;
    logic       pc_write, ir_write, mem_read, mem_write, reg_write, alusrc;
    logic       branch, jump, muldiv_busy, invalid_instr, active;
    logic [1:0] regdst, memtoreg;
    logic [2:0] state;

    typedef struct {
        string       name;
        logic [17:0] v;
    } item_t;
    item_t sbq[$];
    int n_chk = 0;
    int n_fail = 0;

    localparam int KNOP = 0, KWB = 1, KLD = 2, KST = 3, KMD = 4;
    localparam logic [10:0] F_GO   = 11'b01100000001;
    localparam logic [10:0] F_WAIT = 11'b00100000001;
    localparam logic [10:0] ACT    = 11'b00000000001;

    mips_cpu_control_fsm #(.MULT_CYCLES(4), .DIV_CYCLES(32)) dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct), .rt(rt),
        .waitrequest(waitrequest), .pc_zero(pc_zero), .pc_write(pc_write),
        .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .alusrc(alusrc), .branch(branch), .jump(jump),
        .muldiv_busy(muldiv_busy), .invalid_instr(invalid_instr), .active(active),
        .regdst(regdst), .memtoreg(memtoreg), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [17:0] e(logic [2:0] s, logic [10:0] f, logic [1:0] rd, logic [1:0] mt);
        return {s, f, rd, mt};
    endfunction

    task automatic push(string n, logic [17:0] v);
        item_t it;
        it.name = n;
        it.v = v;
        sbq.push_back(it);
    endtask

    task automatic cyc(string n, logic wr, logic [17:0] v);
        waitrequest = wr;
        push(n, v);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(string n);
        #2;
        push({n, ":async"}, e(3'd0, ACT, 2'b00, 2'b00));
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        cyc({n, ":hold"}, 1'b0, e(3'd0, ACT, 2'b00, 2'b00));
        reset_n = 1'b1;
    endtask

    task automatic instr(string n, logic [5:0] op, logic [5:0] fn, logic [4:0] r, int fs,
                         int kind, int stall, logic as, logic br, logic jp, logic inv,
                         logic [1:0] rd, logic [1:0] mt);
        opcode = op;
        funct = fn;
        rt = r;
        for (int i = 0; i < fs; i++) cyc({n, ":fetchwait"}, 1'b1, e(3'd0, F_WAIT, 2'b00, 2'b00));
        cyc({n, ":fetch"}, 1'b0, e(3'd0, F_GO, 2'b00, 2'b00));
        cyc({n, ":decode"}, 1'b0, e(3'd1, {5'b0, as, 4'b0, 1'b1}, rd, mt));
        cyc({n, ":exec"}, 1'b0, e(3'd2, {1'b1, 4'b0, as, br, jp, 1'b0, inv, 1'b1}, rd, mt));
        if (kind == KLD) begin
            for (int i = 0; i < stall; i++) cyc({n, ":memwait"}, 1'b1, e(3'd3, {2'b0, 1'b1, 2'b0, as, 4'b0, 1'b1}, rd, mt));
            cyc({n, ":mem"}, 1'b0, e(3'd3, {2'b0, 1'b1, 2'b0, as, 4'b0, 1'b1}, rd, mt));
        end
        if (kind == KST) begin
            for (int i = 0; i < stall; i++) cyc({n, ":memwait"}, 1'b1, e(3'd3, {3'b0, 1'b1, 1'b0, as, 4'b0, 1'b1}, rd, mt));
            cyc({n, ":mem"}, 1'b0, e(3'd3, {3'b0, 1'b1, 1'b0, as, 4'b0, 1'b1}, rd, mt));
        end
        if (kind == KWB || kind == KLD)
            cyc({n, ":wb"}, 1'b0, e(3'd4, {4'b0, 1'b1, as, 4'b0, 1'b1}, rd, mt));
        if (kind == KMD)
            for (int i = 0; i < stall; i++) cyc({n, ":busy"}, 1'b0, e(3'd5, 11'b00000000101, rd, mt));
    endtask

    initial begin
        item_t it;
        logic [17:0] act_v;
        forever begin
            @(negedge clk or negedge reset_n);
            #1;
            if (sbq.size() > 0) begin
                it = sbq.pop_front();
                act_v = {state, pc_write, ir_write, mem_read, mem_write, reg_write, alusrc,
                         branch, jump, muldiv_busy, invalid_instr, active, regdst, memtoreg};
                n_chk++;
                if (act_v !== it.v) begin
                    n_fail++;
                    $display("FAIL %s: got %b required %b (state,strobes,regdst,memtoreg)", it.name, act_v, it.v);
                end
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        waitrequest = 1'b0;
        pc_zero = 1'b0;
        opcode = 6'd0;
        funct = 6'd0;
        rt = 5'd0;
        @(posedge clk);
        #1;
        cyc("rst0", 1'b0, e(3'd0, ACT, 2'b00, 2'b00));
        cyc("rst1", 1'b0, e(3'd0, ACT, 2'b00, 2'b00));
        reset_n = 1'b1;
        //    name      op     fn     rt       fs kind st  as br jp inv rd     mt
        instr("addu",   6'd0,  6'h21, 5'd0,    0, KWB,  0, 0, 0, 0, 0, 2'b01, 2'b00);
        instr("lw",     6'd35, 6'h00, 5'd0,    0, KLD,  3, 1, 0, 0, 0, 2'b00, 2'b01);
        instr("sw",     6'd43, 6'h00, 5'd0,    0, KST,  2, 1, 0, 0, 0, 2'b00, 2'b00);
        instr("mult",   6'd0,  6'h18, 5'd0,    0, KMD,  4, 0, 0, 0, 0, 2'b00, 2'b00);
        instr("multu",  6'd0,  6'h19, 5'd0,    0, KMD,  4, 0, 0, 0, 0, 2'b00, 2'b00);
        instr("div",    6'd0,  6'h1A, 5'd0,    0, KMD, 32, 0, 0, 0, 0, 2'b00, 2'b00);
        instr("divu",   6'd0,  6'h1B, 5'd0,    0, KMD, 32, 0, 0, 0, 0, 2'b00, 2'b00);
        instr("bgezal", 6'd1,  6'h00, 5'b10001,0, KWB,  0, 0, 1, 0, 0, 2'b10, 2'b10);
        instr("bgez",   6'd1,  6'h00, 5'b00001,0, KNOP, 0, 0, 1, 0, 0, 2'b00, 2'b00);
        instr("jr",     6'd0,  6'h08, 5'd0,    0, KNOP, 0, 0, 0, 1, 0, 2'b00, 2'b00);
        instr("jalr",   6'd0,  6'h09, 5'd0,    0, KWB,  0, 0, 0, 1, 0, 2'b01, 2'b10);
        instr("jal",    6'd3,  6'h00, 5'd0,    0, KWB,  0, 0, 0, 1, 0, 2'b10, 2'b10);
        instr("j",      6'd2,  6'h00, 5'd0,    0, KNOP, 0, 0, 0, 1, 0, 2'b00, 2'b00);
        instr("beq",    6'd4,  6'h00, 5'd0,    0, KNOP, 0, 0, 1, 0, 0, 2'b00, 2'b00);
        instr("mthi",   6'd0,  6'h11, 5'd0,    0, KNOP, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        instr("ori",    6'd13, 6'h00, 5'd0,    2, KWB,  0, 1, 0, 0, 0, 2'b00, 2'b00);
        instr("lui",    6'd15, 6'h00, 5'd0,    0, KWB,  0, 1, 0, 0, 0, 2'b00, 2'b00);
        instr("lbu",    6'd36, 6'h00, 5'd0,    0, KLD,  0, 1, 0, 0, 0, 2'b00, 2'b01);
        instr("sb",     6'd40, 6'h00, 5'd0,    0, KST,  0, 1, 0, 0, 0, 2'b00, 2'b00);
        instr("op3f",   6'd63, 6'h00, 5'd0,    0, KNOP, 0, 0, 0, 0, 1, 2'b00, 2'b00);
        instr("op08",   6'd8,  6'h00, 5'd0,    0, KNOP, 0, 0, 0, 0, 1, 2'b00, 2'b00);
        instr("addiu",  6'd9,  6'h00, 5'd0,    0, KWB,  0, 1, 0, 0, 0, 2'b00, 2'b00);
        pc_zero = 1'b1;
        cyc("halt:fetch", 1'b0, e(3'd0, ACT, 2'b00, 2'b00));
        pc_zero = 1'b0;
        for (int i = 0; i < 3; i++) cyc("halt:hold", i[0], e(3'd6, 11'b0, 2'b00, 2'b00));
        do_reset("halt_rst");
        opcode = 6'd43;
        cyc("rsw:fetch", 1'b0, e(3'd0, F_GO, 2'b00, 2'b00));
        cyc("rsw:decode", 1'b0, e(3'd1, 11'b00000100001, 2'b00, 2'b00));
        cyc("rsw:exec", 1'b0, e(3'd2, 11'b10000100001, 2'b00, 2'b00));
        cyc("rsw:mem", 1'b1, e(3'd3, 11'b00010100001, 2'b00, 2'b00));
        do_reset("rsw_rst");
        cyc("rsw:refetch", 1'b0, e(3'd0, F_GO, 2'b00, 2'b00));
        #10;
        n_chk++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", sbq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
